mac_operand_sequencer: RTL and testbench
========================================

// Module: mac_operand_sequencer
// PURPOSE
//  Initiator side of the multiply-accumulate operand interface. On start it clears the MAC,
//  then streams LENGTH operand pairs from a valid/ready source onto mac_in_a/b/enable.
//  It waits out the MAC pipeline, then returns the final accumulator on a valid/ready result port.
//  Sits between the operand buffer and multiply_accumulate; one dot product per command.
// PARAMETERS
//  DATA_W   16  operand width (mac_in_a/mac_in_b, op_a/op_b)
//  ACC_W    32  accumulator/result width
//  LEN_W    8   width of length (max pairs per command = 2**LEN_W-1)
//  MAC_LAT  3   edges from the MAC sampling enable=1 to its out reflecting that pair
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  start       in   1       command strobe; sampled only in IDLE
//  length      in   LEN_W   number of pairs; latched with start
//  busy        out  1       1 in every state except IDLE
//  op_valid    in   1       operand pair available
//  op_ready    out  1       sequencer accepts pair (STREAM only)
//  op_a, op_b  in   DATA_W  operand pair
//  mac_in_a    out  DATA_W  to MAC in_a (registered)
//  mac_in_b    out  DATA_W  to MAC in_b (registered)
//  mac_enable  out  1       to MAC enable (registered)
//  mac_clear   out  1       to MAC clear (registered)
//  mac_out     in   ACC_W   MAC accumulator
//  res_valid   out  1       result available
//  res_ready   in   1       result consumer ready
//  res_data    out  ACC_W   captured result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy, op_ready, mac_enable, mac_clear, res_valid = 0;
//    mac_in_a/b, res_data, remaining count, drain count = 0. Reset mid-command abandons it silently.
//  - FSM IDLE->CLEAR->STREAM->DRAIN->RESULT->IDLE.
//  - IDLE: start=1 latches length into remaining and goes to CLEAR. start in any other state is ignored.
//  - CLEAR: mac_clear=1 for exactly this one cycle. Next state: STREAM if remaining!=0, else DRAIN.
//  - STREAM: op_ready=1 (combinational from state). A transfer is op_valid&op_ready at an edge.
//    On a transfer edge: mac_in_a<=op_a, mac_in_b<=op_b, mac_enable<=1, remaining-=1.
//    On a non-transfer edge: mac_enable<=0 and mac_in_a/b hold. Gaps insert idle MAC cycles.
//    The transfer with remaining==1 moves to DRAIN and loads drain count=MAC_LAT.
//  - DRAIN: mac_enable=0. Drain count decrements each edge. On the edge where drain count==0:
//    res_data<=mac_out, res_valid<=1, state RESULT. DRAIN lasts MAC_LAT+1 cycles in total.
//  - RESULT: res_valid=1. res_data is stable until res_valid&res_ready; on that edge res_valid<=0 and
//    state goes to IDLE. With res_ready held high, res_valid is high for exactly one cycle.
//  - Arithmetic: the MAC wraps mod 2**ACC_W and the sequencer passes mac_out unmodified.
//    length=0 yields one clear, no enables, res_data=0.
//  - Exactly length mac_enable pulses per command; op_ready is never high outside STREAM.
// CONFIGURATION
//  MAC_SEQ_ABORT_EN defined: adds port abort (in, 1).
//    In any non-IDLE state, abort=1 forces op_ready=0 that cycle, so no transfer occurs.
//    At the next edge: state=IDLE, mac_enable<=0, res_valid<=0, mac_clear<=1 for one cycle.
//    abort in IDLE has no effect.
//  MAC_SEQ_ABORT_EN undefined: no abort port; a command can end only by completion or reset.
// TESTING
//  1. length=3; pairs (2,3),(4,5),(6,7) back-to-back; res_ready=1
//     -> one mac_clear cycle, 3 consecutive enable cycles, res_data=32'd68, res_valid high 1 cycle.
//  2. length=0 -> one mac_clear, zero enables, res_valid after MAC_LAT+1 DRAIN cycles, res_data=0.
//  3. length=2; (0xFFFF,0xFFFF) twice with a 2-cycle op_valid gap; res_ready low 5 cycles
//     -> res_data=32'hFFFC0002 (wrap), held stable with res_valid=1 until res_ready.
//  4. Run (1,1) length 1, then start pulsed during the run, then run (2,2) length 1
//     -> results 1 then 4; the mid-run start is ignored.
//  5. rst_n low during STREAM after 1 of 3 pairs -> all outputs 0 with no clock edge, IDLE;
//     a following length=1 (3,5) run returns 15.
//  6. MAC_SEQ_ABORT_EN: abort during STREAM after 1 of 3 pairs
//     -> one mac_clear pulse, IDLE, busy=0, res_valid never asserted.

Source files
------------

// File: rtl/mac_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_sequencer_if
// Brief    : Operand stream (valid/ready) and result port (valid/ready)
//            of the MAC operand sequencer.
// Revision : 1.0
// ============================================================================
interface mac_operand_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

    // slave: the sequencer (consumes operands, produces the result)
    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data
    );

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data
    );
endinterface
`default_nettype wire

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_sequencer
// Brief    : Clears the MAC, streams LENGTH operand pairs into it, waits out
//            its pipeline and returns the accumulator. Optional abort port is
//            enabled by defining MAC_SEQ_ABORT_EN.
// Revision : 1.0
// ============================================================================
module mac_operand_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       length,
    output logic                   busy,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    mac_operand_sequencer_if.slave bus,
    output logic [DATA_W-1:0]      mac_in_a,
    output logic [DATA_W-1:0]      mac_in_b,
    output logic                   mac_enable,
    output logic                   mac_clear,
    input  logic [ACC_W-1:0]       mac_out
);

    localparam int c_DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(MAC_LAT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LEN_W-1:0]       r_remaining;
    logic [c_DRAIN_W-1:0]   r_drain;
    logic [DATA_W-1:0]      r_mac_in_a;
    logic [DATA_W-1:0]      r_mac_in_b;
    logic                   r_mac_enable;
    logic                   r_mac_clear;
    logic                   r_res_valid;
    logic [ACC_W-1:0]       r_res_data;
    logic                   w_abort;
    logic                   w_start_cmd;
    logic                   w_xfer;

`ifdef MAC_SEQ_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_start_cmd  = (r_state == S_IDLE) && start;
    assign bus.op_ready = (r_state == S_STREAM) && !w_abort;
    assign w_xfer       = bus.op_valid && bus.op_ready;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_CLEAR;
            S_CLEAR:  w_state_next = (r_remaining != '0) ? S_STREAM : S_DRAIN;
            S_STREAM: if (w_xfer && (r_remaining == LEN_W'(1))) w_state_next = S_DRAIN;
            S_DRAIN:  if (r_drain == '0) w_state_next = S_RESULT;
            S_RESULT: if (bus.res_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (w_abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining  <= '0;
            r_drain      <= '0;
            r_mac_in_a   <= '0;
            r_mac_in_b   <= '0;
            r_mac_enable <= 1'b0;
            r_mac_clear  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
        end else begin
            // an abort re-clears the MAC so a partial sum never leaks into the next command
            r_mac_clear  <= w_start_cmd || w_abort;
            r_mac_enable <= w_xfer;
            r_res_valid  <= (w_state_next == S_RESULT);

            if (w_xfer) begin
                r_mac_in_a <= bus.op_a;
                r_mac_in_b <= bus.op_b;
            end

            if (w_start_cmd) begin
                r_remaining <= length;
            end else if (w_xfer) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end

            if ((r_state != S_DRAIN) && (w_state_next == S_DRAIN)) begin
                r_drain <= c_DRAIN_LOAD;
            end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
                r_drain <= r_drain - c_DRAIN_W'(1);
            end

            if ((r_state == S_DRAIN) && (w_state_next == S_RESULT)) begin
                r_res_data <= mac_out;
            end
        end
    end

    assign mac_in_a      = r_mac_in_a;
    assign mac_in_b      = r_mac_in_b;
    assign mac_enable    = r_mac_enable;
    assign mac_clear     = r_mac_clear;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_sequencer
// Brief    : Directed bench for mac_operand_sequencer with a behavioural MAC
//            (result visible MAC_LAT edges after the sampling edge, inclusive).
// Revision : 1.0
// ============================================================================
module tb_mac_operand_sequencer;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 3;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              start  = 1'b0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
`ifdef MAC_SEQ_ABORT_EN
    logic              abort  = 1'b0;
`endif
    logic [DATA_W-1:0] mac_in_a;
    logic [DATA_W-1:0] mac_in_b;
    logic              mac_enable;
    logic              mac_clear;
    logic [ACC_W-1:0]  mac_out;
    logic [ACC_W-1:0]  m_acc = '0;
    logic [ACC_W-1:0]  m_d1  = '0;
    logic [ACC_W-1:0]  m_d2  = '0;

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt, en_run, en_max, clr_cnt, rv_cnt, bad_ready;

    mac_operand_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus_if ();

    mac_operand_sequencer #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .length    (length),
        .busy      (busy),
`ifdef MAC_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus_if.slave),
        .mac_in_a  (mac_in_a),
        .mac_in_b  (mac_in_b),
        .mac_enable(mac_enable),
        .mac_clear (mac_clear),
        .mac_out   (mac_out)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mac_clear) m_acc <= '0;
        else if (mac_enable) m_acc <= m_acc + ACC_W'(mac_in_a) * ACC_W'(mac_in_b);
        m_d1 <= m_acc;
        m_d2 <= m_d1;
    end
    assign mac_out = m_d2;

    always @(negedge clk) begin
        if (mac_enable) begin
            en_cnt++;
            en_run++;
            if (en_run > en_max) en_max = en_run;
        end else begin
            en_run = 0;
        end
        if (mac_clear) clr_cnt++;
        if (bus_if.res_valid) rv_cnt++;
        if (bus_if.op_ready && (!busy || mac_clear || bus_if.res_valid)) bad_ready++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        en_cnt = 0; en_run = 0; en_max = 0; clr_cnt = 0; rv_cnt = 0; bad_ready = 0;
    endtask

    task automatic start_cmd(input logic [LEN_W-1:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int k = 0;
        bus_if.op_valid = 1'b1;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        while (!bus_if.op_ready && k < 20) begin
            tick();
            k++;
        end
        check("op_ready_wait", 64'(k < 20), 64'd1);
        tick();
        bus_if.op_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int k = 0;
        while (!bus_if.res_valid && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, 64'(k < 40), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.op_valid  = 1'b0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.res_ready = 1'b1;
        clear_mon();
        #2;
        check("rst_busy",      64'(busy),             64'd0);
        check("rst_op_ready",  64'(bus_if.op_ready),  64'd0);
        check("rst_enable",    64'(mac_enable),       64'd0);
        check("rst_clear",     64'(mac_clear),        64'd0);
        check("rst_res_valid", 64'(bus_if.res_valid), 64'd0);
        check("rst_res_data",  64'(bus_if.res_data),  64'd0);
        check("rst_mac_in_a",  64'(mac_in_a),         64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: three back-to-back pairs -> 2*3 + 4*5 + 6*7 = 68
        clear_mon();
        start_cmd(8'd3);
        check("t1_clear", 64'(mac_clear), 64'd1);
        check("t1_busy",  64'(busy),      64'd1);
        send_pair(16'd2, 16'd3);
        send_pair(16'd4, 16'd5);
        send_pair(16'd6, 16'd7);
        wait_result("t1");
        check("t1_res_data", 64'(bus_if.res_data), 64'd68);
        tick(); tick();
        check("t1_rv_cycles", 64'(rv_cnt),  64'd1);
        check("t1_clears",    64'(clr_cnt), 64'd1);
        check("t1_enables",   64'(en_cnt),  64'd3);
        check("t1_en_run",    64'(en_max),  64'd3);
        check("t1_idle",      64'(busy),    64'd0);

        // 2: length 0 -> clear, four DRAIN cycles, result 0
        clear_mon();
        start_cmd(8'd0);
        check("t2_clear", 64'(mac_clear), 64'd1);
        tick();
        check("t2_clear_once", 64'(mac_clear), 64'd0);
        tick(); tick(); tick();
        check("t2_rv_early", 64'(bus_if.res_valid), 64'd0);
        tick();
        check("t2_rv",       64'(bus_if.res_valid), 64'd1);
        check("t2_res_data", 64'(bus_if.res_data),  64'd0);
        tick();
        check("t2_rv_drop", 64'(bus_if.res_valid), 64'd0);
        check("t2_enables", 64'(en_cnt),  64'd0);
        check("t2_clears",  64'(clr_cnt), 64'd1);

        // 3: wrapping sum with a gap, result held while res_ready is low
        clear_mon();
        bus_if.res_ready = 1'b0;
        start_cmd(8'd2);
        send_pair(16'hFFFF, 16'hFFFF);
        tick(); tick();
        send_pair(16'hFFFF, 16'hFFFF);
        wait_result("t3");
        check("t3_res_data", 64'(bus_if.res_data), 64'hFFFC0002);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", 64'(bus_if.res_valid), 64'd1);
            check("t3_hold_data",  64'(bus_if.res_data),  64'hFFFC0002);
        end
        bus_if.res_ready = 1'b1;
        tick();
        check("t3_rv_drop", 64'(bus_if.res_valid), 64'd0);
        check("t3_idle",    64'(busy),   64'd0);
        check("t3_enables", 64'(en_cnt), 64'd2);
        check("t3_en_run",  64'(en_max), 64'd1);

        // 4: start pulses mid-command are ignored
        clear_mon();
        start_cmd(8'd1);
        start = 1'b1; length = 8'd5;
        tick();
        start = 1'b0;
        send_pair(16'd1, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_result("t4a");
        check("t4a_res_data", 64'(bus_if.res_data), 64'd1);
        tick(); tick();
        check("t4a_idle",    64'(busy),    64'd0);
        check("t4a_enables", 64'(en_cnt),  64'd1);
        check("t4a_clears",  64'(clr_cnt), 64'd1);
        start_cmd(8'd1);
        send_pair(16'd2, 16'd2);
        wait_result("t4b");
        check("t4b_res_data", 64'(bus_if.res_data), 64'd4);
        tick(); tick();

        // 5: asynchronous reset in the middle of a stream
        start_cmd(8'd3);
        send_pair(16'd3, 16'd4);
        check("t5_pre_enable", 64'(mac_enable), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy",      64'(busy),             64'd0);
        check("t5_op_ready",  64'(bus_if.op_ready),  64'd0);
        check("t5_enable",    64'(mac_enable),       64'd0);
        check("t5_clear",     64'(mac_clear),        64'd0);
        check("t5_res_valid", 64'(bus_if.res_valid), 64'd0);
        check("t5_res_data",  64'(bus_if.res_data),  64'd0);
        check("t5_mac_in_a",  64'(mac_in_a),         64'd0);
        check("t5_mac_in_b",  64'(mac_in_b),         64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_cmd(8'd1);
        send_pair(16'd3, 16'd5);
        wait_result("t5");
        check("t5_res_after", 64'(bus_if.res_data), 64'd15);
        tick(); tick();

`ifdef MAC_SEQ_ABORT_EN
        // 6: abort after one of three pairs
        clear_mon();
        start_cmd(8'd3);
        send_pair(16'd1, 16'd2);
        bus_if.op_valid = 1'b1;
        bus_if.op_a = 16'd9;
        bus_if.op_b = 16'd9;
        abort = 1'b1;
        #1;
        check("t6_ready_blocked", 64'(bus_if.op_ready), 64'd0);
        tick();
        abort = 1'b0;
        bus_if.op_valid = 1'b0;
        check("t6_busy",   64'(busy),       64'd0);
        check("t6_clear",  64'(mac_clear),  64'd1);
        check("t6_enable", 64'(mac_enable), 64'd0);
        tick();
        check("t6_clear_once", 64'(mac_clear), 64'd0);
        for (int i = 0; i < 8; i++) tick();
        check("t6_no_result", 64'(rv_cnt),  64'd0);
        check("t6_clears",    64'(clr_cnt), 64'd2);
        check("t6_enables",   64'(en_cnt),  64'd1);
        check("t6_idle",      64'(busy),    64'd0);
`endif

        check("op_ready_outside_stream", 64'(bad_ready), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
